bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_bus_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Bus arbiter: IDLE/SETUP/OWN ownership FSM with hold limit and timeout masking.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin search; default is fixed priority.
module bus_arbiter #(
  parameter int N_REQ    = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [4:0]       select,
  output logic             bus_valid,
  output logic             hold_timeout,
  output logic             idle
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_OWN
  } state_e;

  localparam logic [7:0] MAXH = 8'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [4:0]       sel_q, sel_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             bv_q, bv_d;
  logic             to_q, to_d;
  logic             idle_q, idle_d;

  logic [N_REQ-1:0] elig;
  logic [4:0]       win;
  logic             own_req;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [4:0]       ptr_q, ptr_d;
`endif

  assign elig    = req & ~mask_q;
  assign own_req = |(req & gnt_q);

  // Scan downward so the lowest search offset is the last write.
  always_comb begin : pick
    int               idx;
    logic [N_REQ-1:0] sh;
    win = '0;
    idx = 0;
    sh  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      idx = (int'(ptr_q) + i) % N_REQ;
`else
      idx = i;
`endif
      sh = elig >> idx;
      if (sh[0]) win = 5'(idx);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    bv_d    = bv_q;
    to_d    = 1'b0;
    mask_d  = mask_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        mask_d = '0;
        gnt_d  = '0;
        bv_d   = 1'b0;
        if (|elig) begin
          state_d = S_SETUP;
          gnt_d   = N_REQ'(1) << win;
          sel_d   = win;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          ptr_d   = 5'((int'(win) + 1) % N_REQ);
`endif
        end
      end
      S_SETUP: begin
        if (own_req) begin
          state_d = S_OWN;
          cnt_d   = 8'd1;
          bv_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      S_OWN: begin
        if (!own_req) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          bv_d    = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q < MAXH) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          // Revoked owner sits out exactly the next arbitration.
          state_d = S_IDLE;
          gnt_d   = '0;
          bv_d    = 1'b0;
          cnt_d   = '0;
          to_d    = 1'b1;
          mask_d  = gnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      bv_q    <= 1'b0;
      to_q    <= 1'b0;
      idle_q  <= 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      bv_q    <= bv_d;
      to_q    <= to_d;
      idle_q  <= idle_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign select       = sel_q;
  assign bus_valid    = bv_q;
  assign hold_timeout = to_q;
  assign idle         = idle_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter against a transaction-level ownership model.
// Build with BUS_ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_bus_arbiter;

  localparam int N  = 32;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [4:0]   select;
  logic         bus_valid;
  logic         hold_timeout;
  logic         idle;

  bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk          (clk),
    .clear        (clear),
    .req          (req),
    .gnt          (gnt),
    .select       (select),
    .bus_valid    (bus_valid),
    .hold_timeout (hold_timeout),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic [4:0]   s;
    logic         bv;
    logic         ht;
    logic         id;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Model: who owns the bus and for how many cycles it has owned it.
  int m_owner = -1;
  int m_own = 0;
  int m_sel = 0;
  int m_mask = -1;
  int m_ptr = 0;
  bit m_to = 1'b0;
  int m_to_cnt = 0;
  int dut_to_cnt = 0;

  function automatic int pick(input logic [N-1:0] e, input int start);
    for (int k = 0; k < N; k++) begin
      if (e[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic c);
    logic [N-1:0] e;
    int w;
    if (c) begin
      m_owner = -1; m_own = 0; m_sel = 0;
      m_mask = -1; m_ptr = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      e = r;
      if (m_mask >= 0) e[m_mask] = 1'b0;
      m_mask = -1;
      m_to = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      w = pick(e, m_ptr);
`else
      w = pick(e, 0);
`endif
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_own = 0;
        m_ptr = (w + 1) % N;
      end
    end else begin
      m_to = 1'b0;
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (m_own == MH) begin
        m_to = 1'b1; m_mask = m_owner; m_owner = -1;
        m_to_cnt++;
      end else begin
        m_own++;
      end
    end
  endtask

  function automatic exp_t expected();
    exp_t e;
    logic [N-1:0] one;
    one  = 1;
    e.g  = (m_owner >= 0) ? (one << m_owner) : '0;
    e.s  = 5'(m_sel);
    e.bv = (m_owner >= 0) && (m_own >= 1);
    e.ht = m_to;
    e.id = (m_owner < 0);
    return e;
  endfunction

  task automatic step(input logic [N-1:0] r, input logic c);
    @(negedge clk);
    req = r;
    clear = c;
    model_step(r, c);
    sb.push_back(expected());
  endtask

  // Owner drops its request after k OWN cycles, then reasserts.
  task automatic resp(input logic [N-1:0] base, input int k, input int cycles);
    logic [N-1:0] r;
    for (int i = 0; i < cycles; i++) begin
      r = base;
      if (m_owner >= 0 && m_own == k) r[m_owner] = 1'b0;
      step(r, 1'b0);
    end
  endtask

  exp_t e_q, got;
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e_q = sb.pop_front();
      got = '{g: gnt, s: select, bv: bus_valid, ht: hold_timeout, id: idle};
      n_chk++;
      if (got !== e_q) begin
        n_fail++;
        $display("FAIL outputs t=%0t got gnt=%h sel=%0d bv=%b ht=%b idle=%b want gnt=%h sel=%0d bv=%b ht=%b idle=%b",
                 $time, got.g, got.s, got.bv, got.ht, got.id,
                 e_q.g, e_q.s, e_q.bv, e_q.ht, e_q.id);
      end
      n_chk++;
      if (!$onehot0(gnt)) begin
        n_fail++;
        $display("FAIL gnt_onehot t=%0t got gnt=%h want at most one bit", $time, gnt);
      end
      if (hold_timeout === 1'b1) dut_to_cnt++;
    end
  end

  initial begin
    logic [N-1:0] cur;
    logic         clr;
    step('0, 1'b1);
    step('0, 1'b1);
    repeat (4) step(32'h0000_0014, 1'b0);
    repeat (3) step('0, 1'b0);
    step('0, 1'b1);
    repeat (14) step(32'h0000_0080, 1'b0);
    step('0, 1'b0);
    repeat (3) step(32'h0000_0020, 1'b0);
    step(32'h0000_0020, 1'b1);
    step('0, 1'b0);
    step(32'h0000_0200, 1'b0);
    repeat (3) step('0, 1'b0);
    step('0, 1'b1);
    resp(32'h0000_0208, 2, 40);
    step('0, 1'b1);
    resp(32'hFFFF_FFFF, 1, 110);
    cur = $urandom;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) cur[b] = ~cur[b];
      end
      clr = ($urandom_range(99) == 0);
      step(cur, clr);
    end
    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d left want 0", sb.size());
    end
    n_chk++;
    if (dut_to_cnt != m_to_cnt || m_to_cnt == 0) begin
      n_fail++;
      $display("FAIL timeout_count got %0d want %0d (nonzero)", dut_to_cnt, m_to_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
